// File: rtl/led_pattern_fader.sv
// rtl/led_pattern_fader.sv - per-channel LED brightness fader with shared PWM drive
// Each pattern bit sets a full-on/off target; levels step toward it on a prescaled tick.
module led_pattern_fader #(
  parameter int WIDTH     = 8,
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 3000,
  parameter int FADE_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             en,
  output logic [WIDTH-1:0] led_out,
  output logic             busy,
  output logic             pwm_sync
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   MAX_X     = {1'b0, LVL_MAX};
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(FADE_STEP);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic                step_tick;
  logic [WIDTH-1:0]    pat_q;

  state_t              state      [WIDTH];
  state_t              state_next [WIDTH];
  logic [PWM_BITS-1:0] level      [WIDTH];
  logic [PWM_BITS-1:0] level_next [WIDTH];
  logic [PWM_BITS:0]   up_sum     [WIDTH];
  logic                busy_next;

  assign step_tick = en && (step_cnt == STEP_LAST);

  // Level moves first (using the state held before this cycle), then the FSM
  // looks at the moved level so a tick that lands on the target settles at once.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      level_next[i] = level[i];
      state_next[i] = state[i];
      up_sum[i]     = {1'b0, level[i]} + STEP_X;
      if (step_tick && state[i] == RISE) begin
        level_next[i] = (up_sum[i] > MAX_X) ? LVL_MAX : up_sum[i][PWM_BITS-1:0];
      end else if (step_tick && state[i] == FALL) begin
        level_next[i] = ({1'b0, level[i]} < STEP_X) ? '0
                        : level[i] - STEP_X[PWM_BITS-1:0];
      end
      case (state[i])
        OFF:  if (pat_q[i]) state_next[i] = RISE;
        RISE: begin
          if (!pat_q[i])                    state_next[i] = FALL;
          else if (level_next[i] == LVL_MAX) state_next[i] = ON;
        end
        ON:   if (!pat_q[i]) state_next[i] = FALL;
        FALL: begin
          if (pat_q[i])                 state_next[i] = RISE;
          else if (level_next[i] == '0) state_next[i] = OFF;
        end
        default: state_next[i] = OFF;
      endcase
      if (state_next[i] == RISE || state_next[i] == FALL) busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      pat_q    <= '0;
      led_out  <= '0;
      busy     <= 1'b0;
      pwm_sync <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        level[i] <= '0;
        state[i] <= OFF;
      end
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= (!en || step_tick) ? '0 : step_cnt + 1'b1;
      pat_q    <= pattern_in;
      busy     <= busy_next;
      pwm_sync <= (pwm_cnt == LVL_MAX);
      for (int i = 0; i < WIDTH; i++) begin
        led_out[i] <= (level[i] == LVL_MAX) ? 1'b1 : (level[i] > pwm_cnt);
        level[i]   <= level_next[i];
        state[i]   <= state_next[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_fader.sv
// tb/tb_led_pattern_fader.sv - randomized scoreboard bench for led_pattern_fader
module tb_led_pattern_fader;

  localparam int W  = 8;
  localparam int PB = 4;
  localparam int SD = 4;
  localparam int FS = 4;
  localparam int MX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [W-1:0] pattern_in = '0;
  logic [W-1:0] led_out;
  logic         busy;
  logic         pwm_sync;

  led_pattern_fader #(
    .WIDTH(W), .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(FS)
  ) dut (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .en(en),
    .led_out(led_out), .busy(busy), .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic         busy;
    logic         sync;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: brightness as integers, motion as a direction (-1/0/+1)
  int         m_lvl[W];
  int         m_dir[W];
  int         m_pwm;
  int         m_pres;
  logic [W-1:0] m_pq;

  always @(posedge clk) begin : model
    exp_t e;
    logic tick;
    int   nl, tgt, want;
    e = '0;
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        m_lvl[i] = 0;
        m_dir[i] = 0;
      end
      m_pwm  = 0;
      m_pres = 0;
      m_pq   = '0;
    end else begin
      e.sync = (m_pwm == MX);
      tick   = en && (m_pres == SD - 1);
      for (int i = 0; i < W; i++) begin
        e.led[i] = (m_lvl[i] == MX) || (m_lvl[i] > m_pwm);
        nl = m_lvl[i];
        if (tick && m_dir[i] > 0) nl = (nl + FS > MX) ? MX : nl + FS;
        if (tick && m_dir[i] < 0) nl = (nl - FS < 0) ? 0 : nl - FS;
        m_lvl[i] = nl;
        tgt  = m_pq[i] ? MX : 0;
        want = m_pq[i] ? 1 : -1;
        if (m_dir[i] != 0 && m_dir[i] != want) m_dir[i] = want;
        else m_dir[i] = (nl == tgt) ? 0 : want;
        if (m_dir[i] != 0) e.busy = 1'b1;
      end
      m_pres = (!en || tick) ? 0 : m_pres + 1;
      m_pwm  = (m_pwm + 1) % (MX + 1);
      m_pq   = pattern_in;
    end
    sb.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (led_out !== e.led) begin
        fails++;
        $display("FAIL led_out at %0t: got %b expected %b", $time, led_out, e.led);
      end
      tests++;
      if (busy !== e.busy) begin
        fails++;
        $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
      end
      tests++;
      if (pwm_sync !== e.sync) begin
        fails++;
        $display("FAIL pwm_sync at %0t: got %b expected %b", $time, pwm_sync, e.sync);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pattern_in = 8'hFF;
    run(3);
    rst = 1'b0;
    run(80);
    pattern_in = 8'h00; run(80);
    pattern_in = 8'h18; run(80);
    // rise to level 8, then reverse
    pattern_in = 8'h01; run(10);
    pattern_in = 8'h00; run(30);
    // freeze mid-rise
    pattern_in = 8'h01; run(10);
    en = 1'b0; run(40);
    en = 1'b1; run(30);
    // reset mid-fade
    pattern_in = 8'h00; run(6);
    rst = 1'b1; run(1);
    rst = 1'b0; run(20);
    for (int k = 0; k < 150; k++) begin
      pattern_in = W'($urandom);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; run(1); rst = 1'b0;
      end
      run($urandom_range(1, 30));
    end
    en = 1'b1; pattern_in = 8'h00;
    run(80);
    @(posedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
